// File: rtl/clk_wheel_gen_if.sv
// rtl/clk_wheel_gen_if.sv - configuration and clock-output bundle for clk_wheel_gen
interface clk_wheel_gen_if #(
    parameter int NUM_CLK = 9,
    parameter int DEPTH   = 32
);
    localparam int HPW = $clog2(DEPTH);
    localparam int CHW = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    logic               freeze_i;
    logic               cfg_we_i;
    logic [CHW-1:0]     cfg_ch_i;
    logic               cfg_en_i;
    logic [HPW-1:0]     cfg_hp_i;
    logic [HPW-1:0]     cfg_phase_i;
    logic               cfg_err_o;
    logic [NUM_CLK-1:0] clk_o;
    logic [NUM_CLK-1:0] edge_o;
    logic [NUM_CLK-1:0] active_o;

    modport master (
        output freeze_i, cfg_we_i, cfg_ch_i, cfg_en_i, cfg_hp_i, cfg_phase_i,
        input  cfg_err_o, clk_o, edge_o, active_o
    );

    modport slave (
        input  freeze_i, cfg_we_i, cfg_ch_i, cfg_en_i, cfg_hp_i, cfg_phase_i,
        output cfg_err_o, clk_o, edge_o, active_o
    );
endinterface

// File: rtl/clk_wheel_gen.sv
// rtl/clk_wheel_gen.sv - timing-wheel multi-clock generator
// Each slot holds one toggle request per channel; firing reschedules half a period ahead.
module clk_wheel_gen #(
    parameter int NUM_CLK = 9,
    parameter int DEPTH   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    clk_wheel_gen_if.slave   bus
);
    localparam int HPW = $clog2(DEPTH);
    localparam int AW  = HPW + 1;
    localparam logic [AW-1:0]  DEPTH_W = AW'(DEPTH);
    localparam logic [HPW-1:0] LAST_SLOT = HPW'(DEPTH - 1);

    logic [NUM_CLK-1:0] r_mem [DEPTH];
    logic [HPW-1:0]     r_ptr;
    logic [HPW-1:0]     r_hp [NUM_CLK];
    logic [NUM_CLK-1:0] r_active;
    logic [NUM_CLK-1:0] r_clk;
    logic [NUM_CLK-1:0] r_edge;
    logic               r_err;

    logic [NUM_CLK-1:0] w_mem_nxt [DEPTH];
    logic [HPW-1:0]     w_hp_nxt [NUM_CLK];
    logic [HPW-1:0]     w_ptr_nxt;
    logic [NUM_CLK-1:0] w_active_nxt;
    logic [NUM_CLK-1:0] w_clk_nxt;
    logic               w_err_nxt;
    logic               w_adv;
    logic               w_cfg_ok;
    logic [NUM_CLK-1:0] w_cfg_mask;
    logic [NUM_CLK-1:0] w_cur;
    logic [NUM_CLK-1:0] w_fire;
    logic [HPW-1:0]     w_cfg_slot;

    // Operands never exceed 2*DEPTH-1, so a single conditional subtract wraps.
    function automatic logic [HPW-1:0] wrap_add(input logic [HPW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] s;
        s = {1'b0, a} + b;
        if (s >= DEPTH_W) begin
            s = s - DEPTH_W;
        end
        return s[HPW-1:0];
    endfunction

    always_comb begin
        w_adv      = !bus.freeze_i;
        w_cur      = r_mem[r_ptr];
        w_cfg_ok   = bus.cfg_we_i && (32'(bus.cfg_ch_i) < NUM_CLK) &&
                     (!bus.cfg_en_i || ((bus.cfg_hp_i != '0) && (32'(bus.cfg_phase_i) < DEPTH)));
        w_err_nxt  = bus.cfg_we_i && !w_cfg_ok;
        w_cfg_mask = '0;
        for (int c = 0; c < NUM_CLK; c++) begin
            w_cfg_mask[c] = w_cfg_ok && (32'(bus.cfg_ch_i) == c);
        end
        // A channel being reconfigured this edge neither toggles nor reschedules.
        w_fire     = w_adv ? (w_cur & ~w_cfg_mask) : '0;
        w_cfg_slot = wrap_add(r_ptr, AW'(bus.cfg_phase_i) + (w_adv ? AW'(1) : AW'(0)));

        for (int s = 0; s < DEPTH; s++) begin
            w_mem_nxt[s] = r_mem[s];
        end
        if (w_adv) begin
            w_mem_nxt[r_ptr] = '0;
        end
        for (int c = 0; c < NUM_CLK; c++) begin
            if (w_fire[c]) begin
                w_mem_nxt[wrap_add(r_ptr, AW'(r_hp[c]))][c] = 1'b1;
            end
        end
        // Config is applied last so it overrides both the slot clear and insertions.
        for (int s = 0; s < DEPTH; s++) begin
            w_mem_nxt[s] = w_mem_nxt[s] & ~w_cfg_mask;
        end
        if (w_cfg_ok && bus.cfg_en_i) begin
            w_mem_nxt[w_cfg_slot] = w_mem_nxt[w_cfg_slot] | w_cfg_mask;
        end

        if (w_adv) begin
            w_ptr_nxt = (r_ptr == LAST_SLOT) ? '0 : r_ptr + 1'b1;
        end else begin
            w_ptr_nxt = r_ptr;
        end

        w_clk_nxt    = (r_clk ^ w_fire) & ~w_cfg_mask;
        w_active_nxt = r_active;
        for (int c = 0; c < NUM_CLK; c++) begin
            w_hp_nxt[c] = r_hp[c];
            if (w_cfg_mask[c]) begin
                w_active_nxt[c] = bus.cfg_en_i;
                if (bus.cfg_en_i) begin
                    w_hp_nxt[c] = bus.cfg_hp_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_mem[s] <= '0;
            end
            for (int c = 0; c < NUM_CLK; c++) begin
                r_hp[c] <= '0;
            end
            r_ptr    <= '0;
            r_active <= '0;
            r_clk    <= '0;
            r_edge   <= '0;
            r_err    <= 1'b0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                r_mem[s] <= w_mem_nxt[s];
            end
            for (int c = 0; c < NUM_CLK; c++) begin
                r_hp[c] <= w_hp_nxt[c];
            end
            r_ptr    <= w_ptr_nxt;
            r_active <= w_active_nxt;
            r_clk    <= w_clk_nxt;
            // Strobe whenever the level changes, including a config-forced drop.
            r_edge   <= w_clk_nxt ^ r_clk;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.clk_o     = r_clk;
    assign bus.edge_o    = r_edge;
    assign bus.active_o  = r_active;
    assign bus.cfg_err_o = r_err;
endmodule

// File: tb/tb_clk_wheel_gen.sv
// tb/tb_clk_wheel_gen.sv - scoreboard bench for clk_wheel_gen against a countdown model
module tb_clk_wheel_gen;
    localparam int N     = 9;
    localparam int DEPTH = 32;
    localparam int HPW   = $clog2(DEPTH);
    localparam int CHW   = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [N-1:0] clk;
        logic [N-1:0] edg;
        logic [N-1:0] act;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    clk_wheel_gen_if #(.NUM_CLK(N), .DEPTH(DEPTH)) bus ();

    clk_wheel_gen #(.NUM_CLK(N), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each active channel counts advancing edges down to its next toggle.
    logic [N-1:0] m_level;
    logic [N-1:0] m_active;
    logic [N-1:0] m_old;
    int           m_cnt [N];
    int           m_hp  [N];
    int           m_ch;
    bit           m_valid;
    exp_t         m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level  = '0;
            m_active = '0;
            for (int c = 0; c < N; c++) begin
                m_cnt[c] = 0;
                m_hp[c]  = 0;
            end
            q.delete();
        end else begin
            m_ch    = int'(bus.cfg_ch_i);
            m_valid = bus.cfg_we_i && (m_ch < N) &&
                      (!bus.cfg_en_i || (bus.cfg_hp_i != 0 && int'(bus.cfg_phase_i) < DEPTH));
            m_old   = m_level;
            for (int c = 0; c < N; c++) begin
                if (!bus.freeze_i && m_active[c] && !(m_valid && c == m_ch)) begin
                    m_cnt[c]--;
                    if (m_cnt[c] == 0) begin
                        m_level[c] = ~m_level[c];
                        m_cnt[c]   = m_hp[c];
                    end
                end
            end
            if (m_valid) begin
                m_level[m_ch]  = 1'b0;
                m_active[m_ch] = bus.cfg_en_i;
                if (bus.cfg_en_i) begin
                    m_hp[m_ch]  = int'(bus.cfg_hp_i);
                    m_cnt[m_ch] = int'(bus.cfg_phase_i) + 1;
                end
            end
            m_e.clk = m_level;
            m_e.edg = m_level ^ m_old;
            m_e.act = m_active;
            m_e.err = bus.cfg_we_i && !m_valid;
            q.push_back(m_e);
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {bus.clk_o, bus.edge_o, bus.active_o, bus.cfg_err_o}, '0);
        end else if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            mon_e = q.pop_front();
            chk("clk_o",     32'(bus.clk_o),     32'(mon_e.clk));
            chk("edge_o",    32'(bus.edge_o),    32'(mon_e.edg));
            chk("active_o",  32'(bus.active_o),  32'(mon_e.act));
            chk("cfg_err_o", 32'(bus.cfg_err_o), 32'(mon_e.err));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input bit en, input int hp, input int ph);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_ch_i    = CHW'(ch);
        bus.cfg_en_i    = en;
        bus.cfg_hp_i    = HPW'(hp);
        bus.cfg_phase_i = HPW'(ph);
        step(1);
        bus.cfg_we_i    = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus.freeze_i    = 1'b0;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_ch_i    = '0;
        bus.cfg_en_i    = 1'b0;
        bus.cfg_hp_i    = '0;
        bus.cfg_phase_i = '0;
        repeat (4) @(posedge clk);
        release_reset();
        step(100);

        cfg_write(0, 1'b1, 3, 0);
        step(20);

        cfg_write(1, 1'b1, 3, 1);
        cfg_write(2, 1'b1, 4, 0);
        step(60);

        // Restart ch3 on the very edge its first fall is due.
        cfg_write(3, 1'b1, 31, 31);
        step(62);
        cfg_write(3, 1'b1, 31, 31);
        step(70);

        cfg_write(0, 1'b1, 3, 0);
        step(2);
        bus.freeze_i = 1'b1;
        step(10);
        bus.freeze_i = 1'b0;
        step(10);
        cfg_write(0, 1'b0, 0, 0);
        step(3);

        cfg_write(1, 1'b1, 0, 2);
        step(2);
        cfg_write(N, 1'b1, 5, 0);
        step(2);

        cfg_write(5, 1'b1, 2, 3);
        bus.freeze_i = 1'b1;
        cfg_write(6, 1'b1, 1, 31);
        step(4);
        bus.freeze_i = 1'b0;
        step(40);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                bus.freeze_i = ~bus.freeze_i;
            end
            if ($urandom_range(0, 9) == 0) begin
                cfg_write($urandom_range(0, (1 << CHW) - 1), $urandom_range(0, 3) != 0,
                          $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            end else begin
                step(1);
            end
        end
        bus.freeze_i = 1'b0;
        step(5);

        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_clk",    32'(bus.clk_o),     32'd0);
        chk("async_reset_edge",   32'(bus.edge_o),    32'd0);
        chk("async_reset_active", 32'(bus.active_o),  32'd0);
        chk("async_reset_err",    32'(bus.cfg_err_o), 32'd0);
        repeat (3) @(posedge clk);
        release_reset();
        step(30);
        cfg_write(4, 1'b1, 7, 5);
        step(60);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
